// File: rtl/indicator_7_pkg.sv
// indicator_7_pkg: segment table, code width and FSM state encoding shared by the
// 7-segment indicator encoder and reader.
package indicator_7_pkg;

    localparam int CODE_W = 3;

    localparam logic [6:0] SEG_PAT_0 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_1 = 7'b0101010;
    localparam logic [6:0] SEG_PAT_2 = 7'b1010101;
    localparam logic [6:0] SEG_PAT_3 = 7'b1110000;
    localparam logic [6:0] SEG_PAT_4 = 7'b0001111;
    localparam logic [6:0] SEG_PAT_5 = 7'b1100011;
    localparam logic [6:0] SEG_PAT_6 = 7'b0011100;
    localparam logic [6:0] SEG_PAT_7 = 7'b1111111;

    // Element i of this packed array is SEG_PAT_i.
    localparam logic [7:0][6:0] SEG_TABLE = {SEG_PAT_7, SEG_PAT_6, SEG_PAT_5, SEG_PAT_4,
                                             SEG_PAT_3, SEG_PAT_2, SEG_PAT_1, SEG_PAT_0};

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OFFER  = 2'd2
    } state_t;

endpackage

// File: rtl/indicator_7_seg_decode.sv
// indicator_7_seg_decode: combinational lookup of a 7-bit segment pattern in the
// indicator table, returning a hit flag and the matching code.
module indicator_7_seg_decode
    import indicator_7_pkg::*;
(
    input  logic [6:0]        pattern_i,
    output logic              hit_o,
    output logic [CODE_W-1:0] code_o
);

    always_comb begin
        hit_o  = 1'b0;
        code_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                hit_o  = 1'b1;
                code_o = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/indicator_7_reader.sv
// indicator_7_reader: debounces a sampled segment bus, decodes stable patterns back to
// a code offered over valid/ready, and flags/counts patterns outside the table.
module indicator_7_reader
    import indicator_7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        segments,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_invalid,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [6:0]        seg_q, seg_prev_q, last_pat_q;
    logic [CW-1:0]     cnt_q;
    state_t            state_q;
    logic [CODE_W-1:0] out_code_q;
    logic              out_valid_q, err_invalid_q;
    logic [ERR_W-1:0]  err_count_q;
    logic              hit;
    logic [CODE_W-1:0] code;
    logic              changed, stable;

    indicator_7_seg_decode u_decode (
        .pattern_i (seg_q),
        .hit_o     (hit),
        .code_o    (code)
    );

    assign changed = seg_q != seg_prev_q;
    // The cycle the counter would reach STABLE_CYCLES is the decode cycle.
    assign stable  = !changed && cnt_q == CW'(STABLE_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= '0;
            seg_prev_q    <= '0;
            last_pat_q    <= '0;
            cnt_q         <= '0;
            state_q       <= ST_WAIT;
            out_code_q    <= '0;
            out_valid_q   <= 1'b0;
            err_invalid_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            seg_q         <= segments;
            seg_prev_q    <= seg_q;
            err_invalid_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (seg_q != last_pat_q) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (changed) begin
                        cnt_q <= '0;
                    end else if (stable) begin
                        cnt_q <= CW'(STABLE_CYCLES);
                        if (seg_q == last_pat_q) begin
                            state_q <= ST_WAIT;
                        end else begin
                            last_pat_q <= seg_q;
                            if (hit) begin
                                out_code_q  <= code;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_OFFER;
                            end else begin
                                err_invalid_q <= 1'b1;
                                err_count_q   <= &err_count_q ? err_count_q : err_count_q + 1'b1;
                                state_q       <= ST_WAIT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= seg_q != last_pat_q ? ST_SETTLE : ST_WAIT;
                        cnt_q       <= '0;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign out_code    = out_code_q;
    assign out_valid   = out_valid_q;
    assign err_invalid = err_invalid_q;
    assign err_count   = err_count_q;

endmodule
